// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the 4-phase REQ/ACK clock-domain-crossing handshake.
// Both the source-side sender and the destination-side capture logic use them.
package cdc_hs_pkg;

  typedef logic [1:0] hs_state_t;

  // Handshake phases: idle, request raised, request released awaiting ack fall.
  localparam hs_state_t ST_IDLE = 2'b00;
  localparam hs_state_t ST_REQ  = 2'b01;
  localparam hs_state_t ST_REL  = 2'b10;

  localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
// The reset clears every stage.
module cdc_ack_sync
  import cdc_hs_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], async_in};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_sender.sv
// Source-domain end of a 4-phase REQ/ACK handshake.
// It holds a word on DATA_OUT while REQ_OUT is presented to the destination.
module cdc_hs_sender
  import cdc_hs_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] DATA_IN,
  input  logic                 DATA_VLD,
  output logic                 READY,
  output logic [BUS_WIDTH-1:0] DATA_OUT,
  output logic                 REQ_OUT,
  input  logic                 ACK_IN,
  output logic                 DONE
);

  logic                 ack_s;
  hs_state_t            state_q, state_d;
  logic                 req_q, req_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 done_q, done_d;

  cdc_ack_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK     (CLK),
    .RST     (RST),
    .async_in(ACK_IN),
    .sync_out(ack_s)
  );

  // A stale ACK left high by the destination blocks a new launch.
  assign READY = (state_q == ST_IDLE) & ~ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DATA_VLD && READY) begin
          data_d  = DATA_IN;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign REQ_OUT  = req_q;
  assign DATA_OUT = data_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Bench for cdc_hs_sender: two instances (2- and 3-stage ACK synchronizers)
// compared every cycle against a transaction-level handshake model.
module tb_cdc_hs_sender;

  logic       clk;
  logic       rst;
  logic       data_vld;
  logic [7:0] data_in;
  logic       ack_in   [2];
  logic       ready    [2];
  logic [7:0] data_out [2];
  logic       req_out  [2];
  logic       done     [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: synchronizer depth, ACK delay line, and handshake bookkeeping.
  int         ns      [2];
  bit         hist    [2][4];
  bit         m_busy  [2];
  bit         m_req   [2];
  bit         m_done  [2];
  logic [7:0] m_data  [2];

  cdc_hs_sender #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut2 (
    .CLK(clk), .RST(rst), .DATA_IN(data_in), .DATA_VLD(data_vld),
    .READY(ready[0]), .DATA_OUT(data_out[0]), .REQ_OUT(req_out[0]),
    .ACK_IN(ack_in[0]), .DONE(done[0])
  );

  cdc_hs_sender #(.BUS_WIDTH(8), .NUM_STAGES(3)) dut3 (
    .CLK(clk), .RST(rst), .DATA_IN(data_in), .DATA_VLD(data_vld),
    .READY(ready[1]), .DATA_OUT(data_out[1]), .REQ_OUT(req_out[1]),
    .ACK_IN(ack_in[1]), .DONE(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // The model sees ACK_IN exactly as many edges late as the synchronizer depth.
  task automatic stepModel();
    bit seen;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 1'b0;
        m_req[i]  = 1'b0;
        m_done[i] = 1'b0;
        m_data[i] = 8'h00;
        for (int j = 0; j < 4; j++) hist[i][j] = 1'b0;
      end else begin
        seen      = hist[i][ns[i]-1];
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (data_vld && !seen) begin
            m_data[i] = data_in;
            m_busy[i] = 1'b1;
            m_req[i]  = 1'b1;
          end
        end else if (m_req[i]) begin
          if (seen) m_req[i] = 1'b0;
        end else if (!seen) begin
          m_done[i] = 1'b1;
          m_busy[i] = 1'b0;
        end
        for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = (ack_in[i] === 1'b1);
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready_ns%0d", ns[i]), {31'd0, ready[i]},
          {31'd0, !m_busy[i] && !hist[i][ns[i]-1]});
      chk($sformatf("req_ns%0d", ns[i]), {31'd0, req_out[i]}, {31'd0, m_req[i]});
      chk($sformatf("data_ns%0d", ns[i]), {24'd0, data_out[i]}, {24'd0, m_data[i]});
      chk($sformatf("done_ns%0d", ns[i]), {31'd0, done[i]}, {31'd0, m_done[i]});
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                               input logic a0, input logic a1);
    rst      = r;
    data_vld = v;
    data_in  = d;
    ack_in[0] = a0;
    ack_in[1] = a1;
  endtask

  task automatic tick();
    @(posedge clk);
    stepModel();
    @(negedge clk);
    cyc++;
    checkOutput();
  endtask

  task automatic run(input logic r, input logic v, input logic [7:0] d,
                     input logic a, input int n);
    applyStimulus(r, v, d, a, a);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    ns[0] = 2;
    ns[1] = 3;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_req[i]  = 1'b0;
      m_done[i] = 1'b0;
      m_data[i] = 8'h00;
      for (int j = 0; j < 4; j++) hist[i][j] = 1'b0;
    end

    $display("[TB] reset with ACK_IN unknown then low");
    run(1'b1, 1'b0, 8'h00, 1'bx, 1);
    run(1'b1, 1'b0, 8'h00, 1'b0, 2);
    run(1'b0, 1'b0, 8'h00, 1'b0, 2);

    $display("[TB] basic transfer 0xA5 with 0x3C stalled behind it");
    run(1'b0, 1'b1, 8'hA5, 1'b0, 1);
    run(1'b0, 1'b1, 8'h3C, 1'b0, 3);
    run(1'b0, 1'b1, 8'h3C, 1'b1, 6);
    run(1'b0, 1'b1, 8'h3C, 1'b0, 6);
    run(1'b0, 1'b0, 8'h00, 1'b0, 1);
    run(1'b0, 1'b0, 8'h00, 1'b1, 6);
    run(1'b0, 1'b0, 8'h00, 1'b0, 6);

    $display("[TB] stale ACK in idle blocks launch of 0x11");
    run(1'b0, 1'b0, 8'h00, 1'b1, 4);
    run(1'b0, 1'b1, 8'h11, 1'b1, 3);
    run(1'b0, 1'b1, 8'h11, 1'b0, 6);
    run(1'b0, 1'b0, 8'h00, 1'b0, 1);

    $display("[TB] reset while releasing with ACK held high");
    run(1'b0, 1'b0, 8'h00, 1'b1, 5);
    run(1'b1, 1'b0, 8'h00, 1'b1, 1);
    run(1'b0, 1'b1, 8'h77, 1'b1, 4);
    run(1'b0, 1'b1, 8'h77, 1'b0, 6);
    run(1'b0, 1'b0, 8'h00, 1'b1, 5);
    run(1'b0, 1'b0, 8'h00, 1'b0, 5);

    $display("[TB] randomized traffic with a loose destination responder");
    for (int k = 0; k < 400; k++) begin
      logic a [2];
      for (int i = 0; i < 2; i++) begin
        if (m_req[i])
          a[i] = ($urandom_range(0, 3) == 0) ? 1'b1 : ack_in[i];
        else if (ack_in[i] === 1'b1)
          a[i] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        else
          a[i] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                    8'($urandom), a[0], a[1]);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
